// File: rtl/pfb_analysis_framer_if.sv
// Stream bundle for the PFB analysis framer: L-lane input stream, 2L-lane
// overlapped output stream and the sticky alignment flag.
interface pfb_analysis_framer_if #(
    parameter int L = 4,
    parameter int B = 32
);
    logic [L*B-1:0]   s_axis_tdata;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [2*L*B-1:0] m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             align_err;

    modport slave (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, align_err
    );

    modport master (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, align_err
    );
endinterface

// File: rtl/pfb_analysis_framer.sv
// Analysis-side framer: pairs each input beat with the beat one half-frame
// earlier to build 50%-overlapped 2L-lane frames, with tlast realignment.
module pfb_analysis_framer #(
    parameter int N = 32,
    parameter int L = 4,
    parameter int B = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    pfb_analysis_framer_if.slave bus
);
    localparam int D  = N / (2 * L);
    localparam int JW = (D > 1) ? $clog2(D) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(D - 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t           state_q, state_d;
    logic [JW-1:0]    j_q, j_d;
    logic             rdy_q;
    logic             vld_p0;
    logic             misalign_p0;
    logic [L*B-1:0]   mem [D];
    logic [2*L*B-1:0] data_p1;
    logic             vld_p1;
    logic             last_p1;
    logic             err_q;

    assign vld_p0      = bus.s_axis_tvalid & rdy_q;
    assign misalign_p0 = vld_p0 & bus.s_axis_tlast & (j_q != J_LAST);

    // A misaligned tlast forces the next beat to slot 0 and re-primes the delay line
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        if (vld_p0) begin
            if (misalign_p0) begin
                j_d     = '0;
                state_d = PRIME;
            end else if (j_q == J_LAST) begin
                j_d     = '0;
                state_d = RUN;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= PRIME;
            j_q     <= '0;
            rdy_q   <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            rdy_q   <= 1'b1;
            vld_p1  <= vld_p0 && (state_q == RUN);
            last_p1 <= vld_p0 && (state_q == RUN) && (j_q == J_LAST);
            err_q   <= err_q | misalign_p0;
            // ---- p0 -> p1: old slot data read before this beat overwrites it
            if (vld_p0) begin
                data_p1 <= {bus.s_axis_tdata, mem[j_q]};
            end
        end
    end

    // Delay line is never reset; PRIME keeps stale slots off valid outputs
    always_ff @(posedge aclk) begin
        if (vld_p0) begin
            mem[j_q] <= bus.s_axis_tdata;
        end
    end

    assign bus.s_axis_tready = rdy_q;
    assign bus.m_axis_tdata  = data_p1;
    assign bus.m_axis_tvalid = vld_p1;
    assign bus.m_axis_tlast  = last_p1;
    assign bus.align_err     = err_q;
endmodule

// File: tb/tb_pfb_analysis_framer.sv
// Randomised-gap and directed bench for pfb_analysis_framer against a
// history-based reference model of the overlapped framing.
module tb_pfb_analysis_framer;
    localparam int N = 32;
    localparam int L = 4;
    localparam int B = 32;
    localparam int D = N / (2 * L);

    typedef logic [L*B-1:0]   beat_t;
    typedef logic [2*L*B-1:0] obeat_t;
    typedef struct {
        obeat_t d;
        logic   last;
    } out_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    pfb_analysis_framer_if #(.L(L), .B(B)) bus();

    pfb_analysis_framer #(.N(N), .L(L), .B(B)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    // Reference model: every accepted beat since the last (re)alignment is kept;
    // beat k of that history pairs with beat k-D once k >= D.
    beat_t  hist[$];
    bit     rdy_m = 0;
    bit     exp_vld = 0, exp_last = 0, exp_err = 0;
    obeat_t exp_data = '0;
    int     m_idx;
    out_t   cap[$];
    out_t   ref1[$];

    function automatic logic [B-1:0] lane(obeat_t d, int i);
        return d[i*B +: B];
    endfunction

    task automatic chk(string name, longint got, longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic chkd(string name, obeat_t got, obeat_t want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge aclk) begin
        if (areset) begin
            hist.delete();
            rdy_m = 0; exp_vld = 0; exp_last = 0; exp_err = 0; exp_data = '0;
        end else begin
            exp_vld  = 0;
            exp_last = 0;
            if (bus.s_axis_tvalid && rdy_m) begin
                hist.push_back(bus.s_axis_tdata);
                m_idx = hist.size() - 1;
                if (m_idx >= D) begin
                    exp_vld  = 1;
                    exp_data = {bus.s_axis_tdata, hist[m_idx-D]};
                    exp_last = (m_idx % D) == D - 1;
                end
                if (bus.s_axis_tlast && (m_idx % D) != D - 1) begin
                    exp_err = 1;
                    hist.delete();
                end
            end
            rdy_m = 1;
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            chk("rst_tvalid", bus.m_axis_tvalid, 0);
            chk("rst_tlast", bus.m_axis_tlast, 0);
            chk("rst_tready", bus.s_axis_tready, 0);
            chk("rst_align_err", bus.align_err, 0);
            chkd("rst_tdata", bus.m_axis_tdata, '0);
        end else begin
            chk("tready", bus.s_axis_tready, rdy_m);
            chk("tvalid", bus.m_axis_tvalid, exp_vld);
            chk("tlast", bus.m_axis_tlast, exp_last);
            chk("align_err", bus.align_err, exp_err);
            if (exp_vld && bus.m_axis_tvalid) chkd("tdata", bus.m_axis_tdata, exp_data);
            if (bus.m_axis_tvalid) cap.push_back('{bus.m_axis_tdata, bus.m_axis_tlast});
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(int s0, bit last);
        for (int i = 0; i < L; i++) bus.s_axis_tdata[i*B +: B] = B'(s0 + i);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        @(posedge aclk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle(2);
        areset = 1'b0;
        idle(2);
    endtask

    task automatic chk_lanes(string name, out_t o, int lo, int hi, bit last);
        chk({name, "_lo"}, lane(o.d, 0), lo);
        chk({name, "_lo3"}, lane(o.d, L-1), lo + L - 1);
        chk({name, "_hi"}, lane(o.d, L), hi);
        chk({name, "_hi3"}, lane(o.d, 2*L-1), hi + L - 1);
        chk({name, "_last"}, o.last, last);
    endtask

    task automatic chk_same_as_ref(string name);
        chk({name, "_count"}, cap.size(), ref1.size());
        for (int k = 0; k < cap.size() && k < ref1.size(); k++) begin
            chkd({name, "_data"}, cap[k].d, ref1[k].d);
            chk({name, "_last"}, cap[k].last, ref1[k].last);
        end
    endtask

    int bad;
    int nlast;

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        idle(3);
        chk("hold_rst_tvalid", bus.m_axis_tvalid, 0);
        chk("hold_rst_tready", bus.s_axis_tready, 0);
        chkd("hold_rst_tdata", bus.m_axis_tdata, '0);
        areset = 1'b0;
        idle(2);

        // Continuous ramp
        cap.delete();
        for (int b = 0; b < 12; b++) send(4*b, 1'b0);
        idle(2);
        chk("ramp_count", cap.size(), 8);
        if (cap.size() >= 5) begin
            chk_lanes("ramp_b4", cap[0], 0, 16, 1'b0);
            chk_lanes("ramp_b7", cap[3], 12, 28, 1'b1);
            chk_lanes("ramp_b8", cap[4], 16, 32, 1'b0);
        end
        ref1 = cap;

        // Gapped ramp with random idle lengths
        do_reset();
        cap.delete();
        for (int b = 0; b < 12; b++) begin
            send(4*b, 1'b0);
            idle((b % 2 == 0) ? 1 : $urandom_range(1, 3));
        end
        idle(2);
        chk_same_as_ref("gaps");

        // Mid-run asynchronous reset, restart from 100
        do_reset();
        for (int b = 0; b < 7; b++) send(4*b, 1'b0);
        chk("pre_rst_tvalid", bus.m_axis_tvalid, 1);
        areset = 1'b1;
        #1;
        chk("async_rst_tvalid", bus.m_axis_tvalid, 0);
        chkd("async_rst_tdata", bus.m_axis_tdata, '0);
        idle(2);
        areset = 1'b0;
        idle(2);
        cap.delete();
        for (int k = 0; k < 5; k++) send(100 + 4*k, 1'b0);
        idle(2);
        chk("restart_count", cap.size(), 1);
        if (cap.size() >= 1) chk_lanes("restart_first", cap[0], 100, 116, 1'b0);

        // Aligned tlast
        do_reset();
        cap.delete();
        for (int b = 0; b < 12; b++) send(4*b, b % 4 == 3);
        idle(1);
        chk("aligned_err", bus.align_err, 0);
        chk_same_as_ref("aligned");

        // Misaligned tlast on j=1 while in RUN
        cap.delete();
        send(48, 1'b0);
        send(52, 1'b1);
        chk("mis_beat_valid", bus.m_axis_tvalid, 1);
        chk("mis_err_rise", bus.align_err, 1);
        for (int k = 0; k < 4; k++) send(56 + 4*k, 1'b0);
        for (int k = 0; k < 4; k++) send(72 + 4*k, 1'b0);
        idle(2);
        chk("mis_count", cap.size(), 6);
        if (cap.size() >= 6) begin
            chk_lanes("mis_j0", cap[0], 32, 48, 1'b0);
            chk_lanes("mis_j1", cap[1], 36, 52, 1'b0);
            chk_lanes("mis_resume", cap[2], 56, 72, 1'b0);
            chk_lanes("mis_resume_last", cap[5], 68, 84, 1'b1);
        end
        chk("mis_err_sticky", bus.align_err, 1);
        do_reset();
        chk("mis_err_cleared", bus.align_err, 0);

        // Wrap stress
        cap.delete();
        for (int b = 0; b < 1000; b++) send(4*b, 1'b0);
        idle(2);
        chk("wrap_count", cap.size(), 1000 - D);
        bad = 0;
        nlast = 0;
        for (int k = 0; k < cap.size(); k++) begin
            if (cap[k].last) nlast++;
            if (cap[k].last != (k % D == D - 1)) bad++;
            for (int i = 0; i < L; i++)
                if (lane(cap[k].d, i) != lane(cap[k].d, i + L) - 16) bad++;
        end
        chk("wrap_tlast_count", nlast, (1000 - D) / D);
        chk("wrap_lane_offset", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
